cp0_timer_bank: RTL and testbench
=================================

CP0_TIMER_BANK -- requirements
Module: cp0_timer_bank

Interface
REQ-001 The block SHALL have parameter NUM_TIMERS, default 4, meaning the number of timer channels; legal range is 1..7.
REQ-002 The block SHALL have parameter CNT_W, default 32, meaning the counter/compare width; legal range is 16..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port we_i, input, 1 bit: write enable.
REQ-006 The block SHALL have port waddr_i, input, 5 bits: write address; [4:2] = channel, [1:0] = register.
REQ-007 The block SHALL have port data_i, input, 32 bits: write data.
REQ-008 The block SHALL have port raddr_i, input, 5 bits: read address, same encoding as waddr_i.
REQ-009 The block SHALL have port data_o, output, 32 bits: read data, combinational.
REQ-010 The block SHALL have port timer_int_o, output, NUM_TIMERS bits: per-channel interrupt, registered.
REQ-011 The block SHALL have port timer_irq_o, output, 1 bit: OR of timer_int_o.

Function
REQ-012 Each channel SHALL have four registers: reg 0 COUNT (CNT_W bits); reg 1 COMPARE (CNT_W bits); reg 2 CTRL ([0] EN, [1] PERIODIC, [2] IE); reg 3 STATUS ([0] PEND, write-1-to-clear).
REQ-013 Address 5'h1C SHALL be global PRESCALE[7:0]; 5'h1D..5'h1F and channels >= NUM_TIMERS SHALL be reserved: reads return 0, writes are ignored.
REQ-014 Reads SHALL zero-extend to 32 bits, with unused bits reading 0; writes SHALL use data_i[CNT_W-1:0] and ignore upper bits.
REQ-015 A tick SHALL occur every PRESCALE+1 cycles; the prescaler counter is shared by all channels and restarts at 0 when PRESCALE is written.
REQ-016 On a tick with EN=1, COUNT SHALL increment by 1, wrapping from 2^CNT_W-1 to 0 with no flag.
REQ-017 A match SHALL be a tick where EN=1, COMPARE != 0 and COUNT == COMPARE (value before increment).
REQ-018 On a match, PEND SHALL be set in the next cycle, and the match SHALL control COUNT as follows:
- PERIODIC=1: COUNT loads 0 instead of incrementing.
- PERIODIC=0: EN clears and COUNT holds.
REQ-019 timer_int_o[n] SHALL equal the registered value of PEND & IE, giving 1 cycle latency from a PEND/IE change.
REQ-020 A same-cycle software write to COUNT or CTRL SHALL take priority over the tick update of that register.
REQ-021 A COMPARE write SHALL clear PEND, and it SHALL win over a same-cycle match set.
REQ-022 On a STATUS W1C in the same cycle as a match, set SHALL win and PEND SHALL remain 1.
REQ-023 Write-then-read of the same address in one cycle SHALL return the old value, with no bypass.

Reset
REQ-024 Asserting rst (low) SHALL immediately force the following reset values:
- all COUNT, COMPARE, CTRL and PEND = 0;
- PRESCALE = 0;
- prescaler counter = 0;
- timer_int_o = 0, timer_irq_o = 0.
REQ-025 A reset asserted mid-count SHALL discard pending matches, and on the first clock edge after release counting SHALL NOT start (EN=0).

Configuration
REQ-026 With macro CP0_TIMER_PRESCALE_EN defined, the prescaler and PRESCALE register SHALL be built per REQ-015.
REQ-027 Without CP0_TIMER_PRESCALE_EN, every cycle SHALL be a tick, 5'h1C SHALL read 0, and writes to 5'h1C SHALL be ignored.

Structure
REQ-028 The shared package/defines SHALL hold the following constants; the timer block SHALL NOT redefine them locally:
- register offsets TMR_REG_COUNT/COMPARE/CTRL/STATUS;
- TMR_ADDR_PRESCALE (5'h1C);
- CTRL bit indices;
- WriteEnable and InterruptAssert/NotAssert.
REQ-029 Per-channel state SHALL live in sub-module cp0_timer_chan, instantiated NUM_TIMERS times via generate; the top SHALL hold address decode, the prescaler and the read mux.

Verification
REQ-030 Periodic mode: COMPARE=5, CTRL=3'b111, PRESCALE=0 -> timer_int_o[0] rises 2 cycles after COUNT==5, COUNT reads 0 the next cycle, and the interrupt repeats every 6 ticks.
REQ-031 One-shot mode: CTRL=3'b101, COMPARE=3 -> a single PEND, then EN reads 0 and COUNT holds at 3.
REQ-032 Wrap-around: CNT_W=16, COUNT=16'hFFFF, COMPARE=0, EN=1 -> next tick COUNT=0 and PEND stays 0.
REQ-033 Collisions:
- COMPARE write on a match cycle -> PEND=0.
- STATUS W1C on a match cycle -> PEND=1.
- COUNT write on a tick -> the written value is held.
REQ-034 Prescaler: PRESCALE=3 -> COUNT advances once per 4 cycles (without the macro, once per cycle).
REQ-035 Reset and reserved addresses:
- rst pulsed low mid-count -> all outputs 0 asynchronously.
- Read of 5'h1E, or of channel 5 with NUM_TIMERS=4 -> 0.

Source files
------------

// File: rtl/cp0_timer_bank_pkg.sv
// Shared constants for the CP0 timer bank: register offsets, the PRESCALE address,
// CTRL bit positions and write/interrupt encodings.
package cp0_timer_bank_pkg;

    localparam logic [1:0] TMR_REG_COUNT   = 2'd0;
    localparam logic [1:0] TMR_REG_COMPARE = 2'd1;
    localparam logic [1:0] TMR_REG_CTRL    = 2'd2;
    localparam logic [1:0] TMR_REG_STATUS  = 2'd3;

    localparam logic [4:0] TMR_ADDR_PRESCALE = 5'h1C;

    localparam int unsigned TMR_CTRL_EN       = 0;
    localparam int unsigned TMR_CTRL_PERIODIC = 1;
    localparam int unsigned TMR_CTRL_IE       = 2;
    localparam int unsigned TMR_CTRL_W        = 3;

    localparam logic WriteEnable        = 1'b1;
    localparam logic InterruptAssert    = 1'b1;
    localparam logic InterruptNotAssert = 1'b0;

endpackage

// File: rtl/cp0_timer_chan.sv
// One timer channel: COUNT, COMPARE, CTRL, PEND and the registered interrupt.
// Software writes are pre-decoded by the bank; tick comes from the shared prescaler.
module cp0_timer_chan
    import cp0_timer_bank_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_i,
    input  logic                  we_count_i,
    input  logic                  we_compare_i,
    input  logic                  we_ctrl_i,
    input  logic                  we_status_i,
    input  logic [31:0]           data_i,
    output logic [CNT_W-1:0]      count_o,
    output logic [CNT_W-1:0]      compare_o,
    output logic [TMR_CTRL_W-1:0] ctrl_o,
    output logic                  pend_o,
    output logic                  int_o
);

    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      compare_q, compare_d;
    logic [TMR_CTRL_W-1:0] ctrl_q, ctrl_d;
    logic                  pend_q, pend_d;
    logic                  int_q, int_d;
    logic                  en, periodic, match;
    logic                  unused_data;

    assign unused_data = ^data_i;

    always_comb begin
        en        = ctrl_q[TMR_CTRL_EN];
        periodic  = ctrl_q[TMR_CTRL_PERIODIC];
        match     = tick_i && en && (compare_q != '0) && (count_q == compare_q);
        count_d   = count_q;
        compare_d = compare_q;
        ctrl_d    = ctrl_q;
        pend_d    = pend_q;
        int_d     = (pend_q && ctrl_q[TMR_CTRL_IE]) ? InterruptAssert : InterruptNotAssert;

        // Software writes take priority over the tick update of the same register.
        if (we_count_i) begin
            count_d = data_i[CNT_W-1:0];
        end else if (match) begin
            if (periodic) count_d = '0;
        end else if (tick_i && en) begin
            count_d = count_q + CNT_W'(1);
        end

        if (we_ctrl_i) begin
            ctrl_d = data_i[TMR_CTRL_W-1:0];
        end else if (match && !periodic) begin
            ctrl_d[TMR_CTRL_EN] = 1'b0;
        end

        if (we_compare_i) compare_d = data_i[CNT_W-1:0];

        // COMPARE write beats a match; a match beats W1C.
        if (we_compare_i) begin
            pend_d = 1'b0;
        end else if (match) begin
            pend_d = 1'b1;
        end else if (we_status_i && data_i[0]) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            compare_q <= '0;
            ctrl_q    <= '0;
            pend_q    <= 1'b0;
            int_q     <= InterruptNotAssert;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ctrl_q    <= ctrl_d;
            pend_q    <= pend_d;
            int_q     <= int_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ctrl_o    = ctrl_q;
    assign pend_o    = pend_q;
    assign int_o     = int_q;

endmodule

// File: rtl/cp0_timer_bank.sv
// CP0 timer bank: address decode, shared prescaler and read mux over NUM_TIMERS channels.
// Define CP0_TIMER_PRESCALE_EN to build the PRESCALE register; otherwise every cycle ticks.
module cp0_timer_bank
    import cp0_timer_bank_pkg::*;
#(
    parameter int unsigned NUM_TIMERS = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           data_i,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           data_o,
    output logic [NUM_TIMERS-1:0] timer_int_o,
    output logic                  timer_irq_o
);

    logic [2:0] wchan, rchan;
    logic [1:0] wreg, rreg;
    logic       tick;

    assign wchan = waddr_i[4:2];
    assign wreg  = waddr_i[1:0];
    assign rchan = raddr_i[4:2];
    assign rreg  = raddr_i[1:0];

`ifdef CP0_TIMER_PRESCALE_EN
    logic [7:0] prescale_q, pcnt_q;
    logic       prescale_we;

    assign prescale_we = (we_i == WriteEnable) && (waddr_i == TMR_ADDR_PRESCALE);
    assign tick        = (pcnt_q == prescale_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else if (prescale_we) begin
            prescale_q <= data_i[7:0];
            pcnt_q     <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    logic [CNT_W-1:0]      count_a   [NUM_TIMERS];
    logic [CNT_W-1:0]      compare_a [NUM_TIMERS];
    logic [TMR_CTRL_W-1:0] ctrl_a    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pend_a;

    // Channel 7 never exists, so the PRESCALE address cannot alias a channel.
    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        logic sel;
        assign sel = (we_i == WriteEnable) && (wchan == 3'(i));

        cp0_timer_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .we_count_i   (sel && (wreg == TMR_REG_COUNT)),
            .we_compare_i (sel && (wreg == TMR_REG_COMPARE)),
            .we_ctrl_i    (sel && (wreg == TMR_REG_CTRL)),
            .we_status_i  (sel && (wreg == TMR_REG_STATUS)),
            .data_i       (data_i),
            .count_o      (count_a[i]),
            .compare_o    (compare_a[i]),
            .ctrl_o       (ctrl_a[i]),
            .pend_o       (pend_a[i]),
            .int_o        (timer_int_o[i])
        );
    end

    always_comb begin
        data_o = '0;
        if (raddr_i == TMR_ADDR_PRESCALE) begin
`ifdef CP0_TIMER_PRESCALE_EN
            data_o = {24'd0, prescale_q};
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
                if (rchan == 3'(i)) begin
                    unique case (rreg)
                        TMR_REG_COUNT:   data_o = 32'(count_a[i]);
                        TMR_REG_COMPARE: data_o = 32'(compare_a[i]);
                        TMR_REG_CTRL:    data_o = 32'(ctrl_a[i]);
                        default:         data_o = {31'd0, pend_a[i]};
                    endcase
                end
            end
        end
    end

    assign timer_irq_o = |timer_int_o;

endmodule

// File: tb/tb_cp0_timer_bank.sv
// Self-checking bench for cp0_timer_bank (NUM_TIMERS=4, CNT_W=16): directed scenarios
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cp0_timer_bank;

`ifdef CP0_TIMER_PRESCALE_EN
    localparam bit PRESC_EN = 1'b1;
`else
    localparam bit PRESC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_o;
    logic [3:0]  timer_int_o;
    logic        timer_irq_o;

    int total = 0;
    int bad   = 0;

    cp0_timer_bank #(
        .NUM_TIMERS (4),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .raddr_i     (raddr_i),
        .data_o      (data_o),
        .timer_int_o (timer_int_o),
        .timer_irq_o (timer_irq_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int unsigned m_cnt [4];
    int unsigned m_cmp [4];
    bit [2:0]    m_ctl [4];
    bit [3:0]    m_pend;
    bit [3:0]    m_int;
    int unsigned m_presc, m_pc;
    bit          m_tk, m_match, m_wr;
    bit [3:0]    m_nint;

    function automatic logic [31:0] mread(input logic [4:0] a);
        int ch;
        ch = int'(a[4:2]);
        if (a == 5'h1C) return PRESC_EN ? m_presc : 32'd0;
        if (ch >= 4) return 32'd0;
        case (a[1:0])
            2'd0:    return m_cnt[ch];
            2'd1:    return m_cmp[ch];
            2'd2:    return {29'd0, m_ctl[ch]};
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                m_cnt[n] = 0;
                m_cmp[n] = 0;
                m_ctl[n] = 3'd0;
            end
            m_pend  = '0;
            m_int   = '0;
            m_presc = 0;
            m_pc    = 0;
        end else begin
            m_tk = PRESC_EN ? (m_pc == m_presc) : 1'b1;
            for (int n = 0; n < 4; n++) begin
                m_wr    = (we_i === 1'b1) && (int'(waddr_i[4:2]) == n);
                m_match = m_tk && m_ctl[n][0] && (m_cmp[n] != 0) && (m_cnt[n] == m_cmp[n]);
                m_nint[n] = m_pend[n] & m_ctl[n][2];
                if (m_wr && waddr_i[1:0] == 2'd1) m_pend[n] = 1'b0;
                else if (m_match) m_pend[n] = 1'b1;
                else if (m_wr && waddr_i[1:0] == 2'd3 && data_i[0]) m_pend[n] = 1'b0;
                if (m_wr && waddr_i[1:0] == 2'd0) m_cnt[n] = data_i & 32'hFFFF;
                else if (m_match) m_cnt[n] = m_ctl[n][1] ? 0 : m_cnt[n];
                else if (m_tk && m_ctl[n][0]) m_cnt[n] = (m_cnt[n] + 1) % 65536;
                if (m_wr && waddr_i[1:0] == 2'd2) m_ctl[n] = data_i[2:0];
                else if (m_match && !m_ctl[n][1]) m_ctl[n][0] = 1'b0;
                if (m_wr && waddr_i[1:0] == 2'd1) m_cmp[n] = data_i & 32'hFFFF;
            end
            m_int = m_nint;
            if (PRESC_EN && we_i === 1'b1 && waddr_i == 5'h1C) begin
                m_presc = data_i & 32'hFF;
                m_pc    = 0;
            end else begin
                m_pc = m_tk ? 0 : m_pc + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rdata", data_o, mread(raddr_i));
        chk("model_int", {28'd0, timer_int_o}, {28'd0, m_int});
        chk("model_irq", {31'd0, timer_irq_o}, {31'd0, |m_int});
    end

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] d,
                        input logic [4:0] ra);
        we_i    = we;
        waddr_i = wa;
        data_i  = d;
        raddr_i = ra;
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] d);
        step(1'b1, wa, d, raddr_i);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'd0, raddr_i);
    endtask

    task automatic peek(input logic [4:0] a, input string name, input logic [31:0] exp);
        we_i    = 1'b0;
        raddr_i = a;
        #1;
        chk(name, data_o, exp);
    endtask

    logic [31:0] c0;
    logic [31:0] rd;

    initial begin
        #2;
        chk("reset_int", {28'd0, timer_int_o}, 32'd0);
        chk("reset_irq", {31'd0, timer_irq_o}, 32'd0);
        peek(5'h00, "reset_count", 32'd0);
        peek(5'h02, "reset_ctrl", 32'd0);
        peek(5'h1C, "reset_prescale", 32'd0);
        #7;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Periodic mode on channel 0
        wr(5'h01, 32'd5);
        wr(5'h02, 32'd7);
        idle(5);
        peek(5'h00, "per_count5", 32'd5);
        chk("per_int_lo", {31'd0, timer_int_o[0]}, 32'd0);
        idle(1);
        peek(5'h00, "per_count0", 32'd0);
        peek(5'h03, "per_pend", 32'd1);
        chk("per_int_still_lo", {31'd0, timer_int_o[0]}, 32'd0);
        idle(1);
        chk("per_int_hi", {31'd0, timer_int_o[0]}, 32'd1);
        chk("per_irq_hi", {31'd0, timer_irq_o}, 32'd1);
        idle(5);
        peek(5'h00, "per_repeat0", 32'd0);

        // Asynchronous reset mid-count
        #2;
        rst = 1'b0;
        #1;
        chk("arst_int", {28'd0, timer_int_o}, 32'd0);
        chk("arst_irq", {31'd0, timer_irq_o}, 32'd0);
        peek(5'h00, "arst_count", 32'd0);
        rst = 1'b1;
        idle(1);
        peek(5'h00, "arst_no_count", 32'd0);
        peek(5'h02, "arst_ctrl", 32'd0);

        // One-shot on channel 1
        wr(5'h05, 32'd3);
        wr(5'h06, 32'd5);
        idle(4);
        peek(5'h06, "os_en_clr", 32'd4);
        peek(5'h04, "os_count", 32'd3);
        peek(5'h07, "os_pend", 32'd1);
        idle(3);
        peek(5'h04, "os_hold", 32'd3);

        // Wrap on channel 2
        wr(5'h08, 32'h1234FFFF);
        wr(5'h0A, 32'd1);
        peek(5'h08, "wrap_ffff", 32'h0000FFFF);
        idle(1);
        peek(5'h08, "wrap_zero", 32'd0);
        peek(5'h0B, "wrap_nopend", 32'd0);
        wr(5'h0A, 32'd0);

        // Collisions on channel 3
        wr(5'h0D, 32'd2);
        wr(5'h0E, 32'd1);
        idle(2);
        wr(5'h0F, 32'd1);
        peek(5'h0F, "col_w1c_set_wins", 32'd1);
        peek(5'h0C, "col_w1c_count", 32'd2);
        wr(5'h0D, 32'd4);
        wr(5'h0E, 32'd1);
        idle(2);
        wr(5'h0D, 32'd4);
        peek(5'h0F, "col_cmp_wins", 32'd0);
        peek(5'h0C, "col_cmp_count", 32'd4);
        wr(5'h0D, 32'd0);
        wr(5'h0E, 32'd1);
        wr(5'h0C, 32'd100);
        peek(5'h0C, "col_count_wr", 32'd100);
        idle(1);
        peek(5'h0C, "col_count_inc", 32'd101);
        wr(5'h0E, 32'd0);

        // Prescaler rate on channel 0
        wr(5'h1C, 32'hFFFFFF03);
        peek(5'h1C, "presc_read", PRESC_EN ? 32'd3 : 32'd0);
        wr(5'h00, 32'd0);
        wr(5'h01, 32'd0);
        wr(5'h02, 32'd1);
        raddr_i = 5'h00;
        #1;
        c0 = data_o;
        idle(8);
        #1;
        rd = data_o - c0;
        chk("presc_rate", rd, PRESC_EN ? 32'd2 : 32'd8);
        wr(5'h1C, 32'd0);
        wr(5'h02, 32'd0);

        // Reserved addresses
        wr(5'h14, 32'hDEAD);
        wr(5'h1E, 32'hBEEF);
        peek(5'h14, "rsv_chan5", 32'd0);
        peek(5'h1E, "rsv_1e", 32'd0);
        peek(5'h1D, "rsv_1d", 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        we;
            logic [4:0]  wa;
            logic [31:0] d;
            we = ($urandom_range(0, 2) == 0);
            wa = 5'($urandom_range(0, 31));
            d  = $urandom;
            if ($urandom_range(0, 3) != 0) d = $urandom_range(0, 12);
            if (wa == 5'h1C) d = $urandom_range(0, 3);
            step(we, wa, d, 5'($urandom_range(0, 31)));
            if (i == 1500) begin
                #2;
                rst = 1'b0;
                #3;
                rst = 1'b1;
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
